acq_udp_packetizer: RTL and testbench
=====================================

ACQ_UDP_PACKETIZER -- requirements
Module: acq_udp_packetizer

Interface
REQ-001 Parameter WORDS_PER_PACKET, default 64, SHALL set the acquisition words per UDP payload (legal 1..4000).
REQ-002 clk  in  1: single clock (rx_xcvr_clk domain); all logic SHALL be synchronous to its rising edge.
REQ-003 reset  in  1: synchronous, active-high reset.
REQ-004 enable  in  1: SHALL permit starting a new packet.
REQ-005 destination_mac  in  48: client MAC.
REQ-006 destination_ip  in  32: client IP.
REQ-007 acq_rdreq  out  1: show-ahead acquisition FIFO read acknowledge.
REQ-008 acq_rddata  in  108: acquisition word, valid whenever acq_rdempty=0.
REQ-009 acq_rdempty  in  1: acquisition FIFO empty.
REQ-010 tx_fifo_data  out  8: payload byte to UDP TX data FIFO.
REQ-011 tx_fifo_data_write  out  1: data FIFO write strobe.
REQ-012 tx_fifo_data_full  in  1: data FIFO full.
REQ-013 tx_fifo_status  out  96: packet descriptor {mac[47:0], ip[31:0], length[15:0]}.
REQ-014 tx_fifo_status_write  out  1: status FIFO write strobe.
REQ-015 tx_fifo_status_full  in  1: status FIFO full.
REQ-016 busy  out  1: high in any state except IDLE.
REQ-017 seq_number  out  32: sequence number of the next packet.

Function
REQ-018 States SHALL be IDLE, HEADER, LOAD, BYTES, STATUS.
REQ-019 IDLE->HEADER SHALL occur when enable=1, acq_rdempty=0 and tx_fifo_status_full=0; destination_mac/ip SHALL be latched that cycle.
REQ-020 HEADER SHALL write seq_number as 4 bytes, MSB first, one byte per cycle in which tx_fifo_data_full=0, then go to LOAD.
REQ-021 LOAD SHALL assert acq_rdreq for exactly one cycle when acq_rdempty=0, capturing {4'b0, acq_rddata} into a 112-bit shift register that cycle, then go to BYTES; LOAD SHALL wait (no rdreq) while acq_rdempty=1.
REQ-022 BYTES SHALL write the 14 captured bytes MSB first, one per cycle in which tx_fifo_data_full=0.
REQ-023 After byte 14: if words sent < WORDS_PER_PACKET go to LOAD, else go to STATUS.
REQ-024 tx_fifo_data_write SHALL never be asserted while tx_fifo_data_full=1; stalled bytes SHALL be held, not dropped.
REQ-025 STATUS SHALL assert tx_fifo_status_write for one cycle when tx_fifo_status_full=0, with length = 4 + 14*WORDS_PER_PACKET (16 bits), then go to IDLE.
REQ-026 seq_number SHALL increment by 1 in the STATUS write cycle, wrapping 0xFFFFFFFF->0.
REQ-027 enable deasserted mid-packet SHALL NOT abort; the current packet completes.
REQ-028 Per-packet word counter SHALL reset to 0 on each IDLE->HEADER.
REQ-029 With no stalls, packet duration SHALL be 1 (IDLE) + 4 + WORDS_PER_PACKET*15 + 1 cycles.

Reset
REQ-030 On reset: state IDLE; acq_rdreq, tx_fifo_data_write, tx_fifo_status_write, busy = 0; tx_fifo_data = 0; tx_fifo_status = 0; seq_number = 0.
REQ-031 Reset mid-packet SHALL abandon the packet without status write; bytes already written are not reclaimed (TX FIFO flush is upstream's responsibility).

Verification
REQ-032 WORDS_PER_PACKET=2, FIFO holds 0x123456789ABCDEF0123456789 and 0x0..01, enable=1 -> bytes 00 00 00 00, 01 23 .. 89, 00 .. 01 (32 bytes), status length=32, seq_number=1.
REQ-033 tx_fifo_data_full toggled every other cycle during BYTES -> identical byte stream, no write while full.
REQ-034 acq_rdempty high 20 cycles between words -> LOAD waits, single rdreq per word, packet intact.
REQ-035 tx_fifo_status_full=1 in STATUS for 10 cycles -> status written exactly once after release; IDLE blocks new packet while full.
REQ-036 Preload seq_number path to 0xFFFFFFFF (run until wrap or force) -> header FF FF FF FF, next seq_number=0.
REQ-037 Reset asserted in BYTES -> next cycle all outputs at REQ-030 values, no status write.

Source files
------------

// File: rtl/acq_udp_packetizer_if.sv
// Acquisition FIFO read side and UDP TX data/status FIFO write side.
interface acq_udp_packetizer_if;
  logic         acq_rdreq;
  logic [107:0] acq_rddata;
  logic         acq_rdempty;
  logic [7:0]   tx_fifo_data;
  logic         tx_fifo_data_write;
  logic         tx_fifo_data_full;
  logic [95:0]  tx_fifo_status;
  logic         tx_fifo_status_write;
  logic         tx_fifo_status_full;

  modport master (
    output acq_rdreq,
    input  acq_rddata,
    input  acq_rdempty,
    output tx_fifo_data,
    output tx_fifo_data_write,
    input  tx_fifo_data_full,
    output tx_fifo_status,
    output tx_fifo_status_write,
    input  tx_fifo_status_full
  );

  modport slave (
    input  acq_rdreq,
    output acq_rddata,
    output acq_rdempty,
    input  tx_fifo_data,
    input  tx_fifo_data_write,
    output tx_fifo_data_full,
    input  tx_fifo_status,
    input  tx_fifo_status_write,
    output tx_fifo_status_full
  );
endinterface

// File: rtl/acq_udp_packetizer.sv
// Packs 108-bit acquisition words into UDP payloads: 4-byte sequence
// header, 14 bytes per word, then one status descriptor per packet.
module acq_udp_packetizer #(
  parameter int WORDS_PER_PACKET = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [47:0] destination_mac,
  input  logic [31:0] destination_ip,
  output logic        busy,
  output logic [31:0] seq_number,
  acq_udp_packetizer_if.master bus
);

  localparam logic [15:0] LENGTH =
    16'(4 + 14 * WORDS_PER_PACKET);
  localparam int WW = $clog2(WORDS_PER_PACKET + 1);
  localparam logic [WW-1:0] WORDS = WW'(WORDS_PER_PACKET);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LOAD,
    BYTES,
    STATUS
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [WW-1:0]   words_q, words_d;
  logic [111:0]    sreg_q, sreg_d;
  logic [47:0]     mac_q, mac_d;
  logic [31:0]     ip_q, ip_d;
  logic [31:0]     seq_q, seq_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      words_q <= '0;
      sreg_q  <= '0;
      mac_q   <= '0;
      ip_q    <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      sreg_q  <= sreg_d;
      mac_q   <= mac_d;
      ip_q    <= ip_d;
      seq_q   <= seq_d;
    end
  end

  // The header shares the byte shifter: seq is parked in the top 32 bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    sreg_d  = sreg_q;
    mac_d   = mac_q;
    ip_d    = ip_q;
    seq_d   = seq_q;

    bus.acq_rdreq            = 1'b0;
    bus.tx_fifo_data         = 8'h00;
    bus.tx_fifo_data_write   = 1'b0;
    bus.tx_fifo_status       = '0;
    bus.tx_fifo_status_write = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && !bus.acq_rdempty &&
            !bus.tx_fifo_status_full) begin
          state_d = HEADER;
          mac_d   = destination_mac;
          ip_d    = destination_ip;
          sreg_d  = {seq_q, 80'b0};
          cnt_d   = '0;
          words_d = '0;
        end
      end
      HEADER: begin
        bus.tx_fifo_data = sreg_q[111:104];
        if (!bus.tx_fifo_data_full) begin
          bus.tx_fifo_data_write = 1'b1;
          sreg_d = sreg_q << 8;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd3) begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (!bus.acq_rdempty) begin
          bus.acq_rdreq = 1'b1;
          sreg_d  = {4'b0, bus.acq_rddata};
          cnt_d   = '0;
          words_d = words_q + 1'b1;
          state_d = BYTES;
        end
      end
      BYTES: begin
        bus.tx_fifo_data = sreg_q[111:104];
        if (!bus.tx_fifo_data_full) begin
          bus.tx_fifo_data_write = 1'b1;
          sreg_d = sreg_q << 8;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd13) begin
            state_d = (words_q < WORDS) ? LOAD : STATUS;
          end
        end
      end
      STATUS: begin
        bus.tx_fifo_status = {mac_q, ip_q, LENGTH};
        if (!bus.tx_fifo_status_full) begin
          bus.tx_fifo_status_write = 1'b1;
          seq_d   = seq_q + 32'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign seq_number = seq_q;

endmodule

// File: tb/tb_acq_udp_packetizer.sv
// Randomized bench for acq_udp_packetizer with a queue-based payload
// model, plus directed vectors, stalls, wrap and mid-packet reset.
module tb_acq_udp_packetizer;

  localparam int W = 2;
  localparam logic [15:0] LEN = 16'(4 + 14 * W);
  localparam logic [47:0] MAC0 = 48'h0A0B_0C0D_0E0F;
  localparam logic [31:0] IP0  = 32'hC0A8_0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable;
  logic [47:0] mac;
  logic [31:0] ip;
  logic        busy;
  logic [31:0] seq_number;

  acq_udp_packetizer_if bus();

  acq_udp_packetizer #(.WORDS_PER_PACKET(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .destination_mac (mac),
    .destination_ip  (ip),
    .busy            (busy),
    .seq_number      (seq_number),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [107:0] rnd_word();
    return {12'($urandom()), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stimulus knobs
  logic [107:0] acq_q[$];
  int  p_full = 0, p_sfull = 0, p_en = 0, p_hide = 0;
  bit  sfull_force = 0, toggle_full = 0, long_gaps = 0;
  bit  rnd_addr = 0, auto_fill = 0, pop_pending = 0;
  int  hide_left = 0;

  // Reference model / scoreboard state
  logic [7:0]  exp_b[$];
  logic [95:0] exp_s[$];
  logic [7:0]  obs[$];
  logic [31:0] model_seq = 0;
  logic [95:0] last_status = '0;
  int words_in_pkt = 0, status_cnt = 0, busy_cycles = 0;
  bit mon_en = 1;

  // Driver: inputs change 1 time unit after the rising edge.
  initial begin
    bit hidden;
    enable = 1'b0;
    mac = MAC0;
    ip = IP0;
    bus.acq_rdempty = 1'b1;
    bus.acq_rddata = '0;
    bus.tx_fifo_data_full = 1'b0;
    bus.tx_fifo_status_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pending) begin
        void'(acq_q.pop_front());
        pop_pending = 0;
        if (long_gaps) hide_left = 20;
      end
      if (auto_fill && acq_q.size() < 6 && $urandom_range(0, 3) == 0)
        acq_q.push_back(rnd_word());
      if (hide_left > 0) hide_left--;
      hidden = (hide_left > 0) || ($urandom_range(0, 99) < p_hide);
      bus.acq_rdempty = hidden || (acq_q.size() == 0);
      bus.acq_rddata = (acq_q.size() != 0) ? acq_q[0] : '0;
      if (toggle_full)
        bus.tx_fifo_data_full = ~bus.tx_fifo_data_full;
      else
        bus.tx_fifo_data_full = ($urandom_range(0, 99) < p_full);
      bus.tx_fifo_status_full = sfull_force ||
                                ($urandom_range(0, 99) < p_sfull);
      enable = ($urandom_range(0, 99) < p_en);
      if (rnd_addr) begin
        mac = {16'($urandom()), $urandom()};
        ip = $urandom();
      end
    end
  end

  // Compare process: outputs sampled mid-cycle, before the edge commits.
  initial begin
    logic [111:0] w;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        if (busy) busy_cycles++;
        chk("seq_number", seq_number, model_seq);
        if (!busy)
          chk("idle_quiet", {bus.acq_rdreq, bus.tx_fifo_data_write,
                             bus.tx_fifo_status_write}, 3'b000);
        if (bus.tx_fifo_data_write) begin
          chk("write_while_full", bus.tx_fifo_data_full, 1'b0);
          obs.push_back(bus.tx_fifo_data);
          if (exp_b.size() == 0)
            chk("unexpected_byte", 1'b1, 1'b0);
          else
            chk("byte", bus.tx_fifo_data, exp_b.pop_front());
        end
        if (bus.acq_rdreq) begin
          chk("rdreq_while_empty", bus.acq_rdempty, 1'b0);
          if (!bus.acq_rdempty && acq_q.size() != 0) begin
            w = {4'b0, acq_q[0]};
            for (int i = 13; i >= 0; i--) exp_b.push_back(w[i*8 +: 8]);
            pop_pending = 1;
            words_in_pkt++;
          end
        end
        if (bus.tx_fifo_status_write) begin
          status_cnt++;
          last_status = bus.tx_fifo_status;
          chk("status_while_full", bus.tx_fifo_status_full, 1'b0);
          if (exp_s.size() == 0)
            chk("unexpected_status", 1'b1, 1'b0);
          else
            chk("status", bus.tx_fifo_status, exp_s.pop_front());
          chk("words_per_packet", words_in_pkt, W);
          chk("bytes_left", exp_b.size(), 0);
          words_in_pkt = 0;
          model_seq = model_seq + 32'd1;
        end
        if (!busy && enable && !bus.acq_rdempty &&
            !bus.tx_fifo_status_full) begin
          exp_s.push_back({mac, ip, LEN});
          for (int i = 3; i >= 0; i--) exp_b.push_back(model_seq[i*8 +: 8]);
          words_in_pkt = 0;
        end
      end
    end
  end

  task automatic wait_busy(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!busy && n < budget);
    chk(name, busy, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (busy && n < budget);
    chk(name, busy, 1'b0);
  endtask

  task automatic wait_status(input int cnt, input int budget,
                             input string name);
    int n = 0;
    while (status_cnt < cnt && n < budget) begin
      @(negedge clk); #1; n++;
    end
    chk(name, status_cnt >= cnt, 1'b1);
  endtask

  logic [7:0] lit[32];
  int n;
  int sw_seen;

  initial begin
    lit = '{8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB,
            8'hCD, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdreq", bus.acq_rdreq, 1'b0);
    chk("rst_data_write", bus.tx_fifo_data_write, 1'b0);
    chk("rst_status_write", bus.tx_fifo_status_write, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", bus.tx_fifo_data, 8'h00);
    chk("rst_status", bus.tx_fifo_status, 96'h0);
    chk("rst_seq", seq_number, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Directed two-word packet, no stalls
    obs.delete();
    busy_cycles = 0;
    acq_q.push_back(108'h123456789ABCDEF0123456789);
    acq_q.push_back(108'h1);
    p_en = 100;
    wait_status(1, 200, "pkt1_timeout");
    p_en = 0;
    chk("lit_byte_count", obs.size(), 32);
    for (int i = 0; i < 32; i++)
      if (i < obs.size()) chk($sformatf("lit_byte%0d", i), obs[i], lit[i]);
    chk("lit_status", last_status, {MAC0, IP0, 16'd32});
    chk("lit_duration", busy_cycles, 35);
    @(negedge clk);
    chk("lit_seq1", seq_number, 32'd1);

    // Data FIFO full toggling every cycle
    toggle_full = 1;
    acq_q.push_back(rnd_word());
    acq_q.push_back(rnd_word());
    p_en = 100;
    wait_busy(50, "pkt2_start");
    p_en = 0;
    wait_status(2, 300, "pkt2_timeout");
    toggle_full = 0;

    // Long acquisition gaps between words
    long_gaps = 1;
    acq_q.push_back(rnd_word());
    acq_q.push_back(rnd_word());
    p_en = 100;
    wait_busy(50, "pkt3_start");
    p_en = 0;
    wait_status(3, 300, "pkt3_timeout");
    long_gaps = 0;
    wait_idle(20, "pkt3_idle");

    // Status FIFO held full across STATUS
    acq_q.push_back(rnd_word());
    acq_q.push_back(rnd_word());
    p_en = 100;
    wait_busy(50, "pkt4_start");
    p_en = 0;
    sfull_force = 1;
    n = 0;
    while (!(words_in_pkt == W && exp_b.size() == 0) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    repeat (10) @(negedge clk);
    #1;
    chk("sfull_hold_count", status_cnt, 3);
    chk("sfull_hold_busy", busy, 1'b1);
    sfull_force = 0;
    wait_status(4, 50, "pkt4_timeout");
    wait_idle(20, "pkt4_idle");
    sfull_force = 1;
    acq_q.push_back(rnd_word());
    acq_q.push_back(rnd_word());
    p_en = 100;
    repeat (10) @(negedge clk);
    #1;
    chk("sfull_blocks_start", busy, 1'b0);
    sfull_force = 0;
    wait_busy(50, "pkt5_start");
    p_en = 0;
    wait_status(5, 200, "pkt5_timeout");

    // Randomized traffic
    rnd_addr = 1;
    auto_fill = 1;
    p_full = 30; p_sfull = 20; p_hide = 20; p_en = 80;
    repeat (2500) @(negedge clk);
    p_en = 0;
    repeat (3) @(negedge clk);
    wait_idle(2000, "drain_idle");
    repeat (3) @(negedge clk);
    wait_idle(2000, "drain_idle2");
    auto_fill = 0;
    rnd_addr = 0;
    p_full = 0; p_sfull = 0; p_hide = 0;
    repeat (2) @(negedge clk);
    chk("random_packets", status_cnt > 20, 1'b1);

    // Sequence number wrap
    @(posedge clk); #2;
    force dut.seq_q = 32'hFFFF_FFFF;
    model_seq = 32'hFFFF_FFFF;
    @(posedge clk); #2;
    release dut.seq_q;
    n = status_cnt;
    obs.delete();
    acq_q.push_back(rnd_word());
    acq_q.push_back(rnd_word());
    p_en = 100;
    wait_busy(50, "wrap_start");
    p_en = 0;
    wait_status(n + 1, 200, "wrap_timeout");
    for (int i = 0; i < 4; i++)
      if (i < obs.size()) chk($sformatf("wrap_hdr%0d", i), obs[i], 8'hFF);
    @(negedge clk);
    chk("wrap_seq0", seq_number, 32'h0);
    wait_idle(50, "wrap_idle");

    // Reset in the middle of a word's bytes
    acq_q.push_back(rnd_word());
    acq_q.push_back(rnd_word());
    n = words_in_pkt;
    p_en = 100;
    wait_busy(50, "rst_pkt_start");
    p_en = 0;
    n = 0;
    while (words_in_pkt < 1 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk); @(negedge clk);
    chk("in_bytes_writing", bus.tx_fifo_data_write, 1'b1);
    mon_en = 0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_rdreq", bus.acq_rdreq, 1'b0);
    chk("mid_rst_data_write", bus.tx_fifo_data_write, 1'b0);
    chk("mid_rst_status_write", bus.tx_fifo_status_write, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data", bus.tx_fifo_data, 8'h00);
    chk("mid_rst_status", bus.tx_fifo_status, 96'h0);
    chk("mid_rst_seq", seq_number, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    sw_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tx_fifo_status_write) sw_seen++;
    end
    chk("mid_rst_no_status", sw_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
